// File: rtl/rb2_link_pkg.sv
// Shared definitions for the serial link into Register Bank 2.
//   ADDR_W   : packet address width (RB2 address width)
//   DATA_W   : packet payload width (RB2 word width)
//   NUM_PKT  : valid packets per transfer before done
//   PKT_BITS : total serial bits per packet
//   state_e  : receiver FSM states
package rb2_link_pkg;

  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 18;
  localparam int unsigned NUM_PKT  = 8;
  localparam int unsigned PKT_BITS = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/serial_shift_rx.sv
// Serial packet deserializer: shift register plus saturating bit counter.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : receive enable; when low the bit counter is held at zero
//   sen       : packet enable, active-low
//   sd        : serial data, MSB first
//   pkt_valid : high for the one cycle in which sen has returned high after
//               exactly PKT_BITS bits
//   pkt_data  : assembled packet, first received bit in the MSB
module serial_shift_rx #(
  parameter int unsigned PKT_BITS = rb2_link_pkg::PKT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sen,
  input  logic                sd,
  output logic                pkt_valid,
  output logic [PKT_BITS-1:0] pkt_data
);

  // Counter must reach PKT_BITS+1, which marks an overlong packet.
  localparam int unsigned     CNT_W    = $clog2(PKT_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PKT_BITS + 1);

  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PKT_BITS-1:0] sr_q, sr_d;

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (!en) begin
      bit_cnt_d = '0;
    end else if (!sen) begin
      // Bits past PKT_BITS are dropped; the saturated count flags the packet.
      if (bit_cnt_q < CNT_FULL) begin
        sr_d = {sr_q[PKT_BITS-2:0], sd};
      end
      if (bit_cnt_q != CNT_SAT) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else begin
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Combinational so the top can register the write on the very edge that
  // samples the closing sen=1.
  assign pkt_valid = en && sen && (bit_cnt_q == CNT_FULL);
  assign pkt_data  = sr_q;

endmodule

// File: rtl/rb2_serial_loader.sv
// Receiver stage of the serial link: reassembles sen/sd packets into an
// address/word pair and writes them into Register Bank 2 with a one-cycle
// write strobe; raises done after NUM_PKT valid packets.
//   clk    : clock, rising-edge
//   rst    : asynchronous active-high reset
//   sen    : packet enable, active-low
//   sd     : serial data, MSB first
//   RB2_RW : 1 = read/idle, 0 = write strobe
//   RB2_A  : RB2 address
//   RB2_D  : RB2 write data
//   RB2_Q  : RB2 read data (unused)
//   done   : sticky completion flag
module rb2_serial_loader #(
  parameter int unsigned ADDR_W  = rb2_link_pkg::ADDR_W,
  parameter int unsigned DATA_W  = rb2_link_pkg::DATA_W,
  parameter int unsigned NUM_PKT = rb2_link_pkg::NUM_PKT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  input  logic [DATA_W-1:0] RB2_Q,
  output logic              done
);

  import rb2_link_pkg::*;

  localparam int unsigned       PKT_W    = ADDR_W + DATA_W;
  localparam int unsigned       PCNT_W   = $clog2(NUM_PKT + 1);
  localparam logic [PCNT_W-1:0] PKT_LAST = PCNT_W'(NUM_PKT);

  state_e              state_q, state_d;
  logic [PCNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic                done_q, done_d;

  logic                rx_en;
  logic                pkt_valid;
  logic [PKT_W-1:0]    pkt_data;
  logic                unused_rb2_q;

  assign unused_rb2_q = ^RB2_Q;
  assign rx_en        = (state_q != DONE);

  serial_shift_rx #(
    .PKT_BITS (PKT_W)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .en        (rx_en),
    .sen       (sen),
    .sd        (sd),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data)
  );

  always_comb begin
    state_d   = state_q;
    pkt_cnt_d = pkt_cnt_q;
    rw_d      = 1'b1;
    a_d       = a_q;
    d_d       = d_q;
    done_d    = done_q;
    case (state_q)
      IDLE: begin
        // The last strobe always ends while in IDLE, so completion is
        // detected here on the edge that ends it.
        if (pkt_cnt_q == PKT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (!sen) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sen) begin
          state_d = IDLE;
          if (pkt_valid) begin
            rw_d      = 1'b0;
            a_d       = pkt_data[PKT_W-1:DATA_W];
            d_d       = pkt_data[DATA_W-1:0];
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pkt_cnt_q <= '0;
      rw_q      <= 1'b1;
      a_q       <= '0;
      d_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_cnt_q <= pkt_cnt_d;
      rw_q      <= rw_d;
      a_q       <= a_d;
      d_q       <= d_d;
      done_q    <= done_d;
    end
  end

  assign RB2_RW = rw_q;
  assign RB2_A  = a_q;
  assign RB2_D  = d_q;
  assign done   = done_q;

endmodule

// File: doc/rb2_serial_loader.md
# rb2_serial_loader

Receiver stage of the serial link: samples the `sen`/`sd` bit stream produced by the upstream register-bank serializer and reassembles each packet into a 3-bit address and an 18-bit word. It writes each word into Register Bank 2 through a single-cycle write strobe. After eight valid packets it raises `done`.

## Interface
- `ADDR_W`, 3, packet address width = RB2 address width
- `DATA_W`, 18, packet payload width = RB2 word width
- `NUM_PKT`, 8, valid packets per transfer before `done`
- `clk`  in  1  clock; all sampling and updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `sen`  in  1  packet enable, active-low; low for exactly the bits of one packet
- `sd`  in  1  serial data, MSB first, valid while `sen`=0
- `RB2_RW`  out  1  RB2 access: 1 = read/idle, 0 = write strobe
- `RB2_A`  out  ADDR_W  RB2 address
- `RB2_D`  out  DATA_W  RB2 write data
- `RB2_Q`  in  DATA_W  RB2 read data; unused, tied off internally
- `done`  out  1  high once `NUM_PKT` writes have completed; sticky until `rst`

## Operation
- Packet format, `ADDR_W+DATA_W` = 21 bits, MSB first:
  - bits 20..18: address A[2:0], A[2] first.
  - bits 17..0: word D[17:0], D[17] first.
- Packets are separated by at least one cycle with `sen`=1.
- FSM states:
  - IDLE: wait for `sen`=0.
  - SHIFT: accumulate bits.
  - DONE: terminal.
- IDLE→SHIFT: first rising edge with `sen`=0. That bit is shifted in and `bit_cnt` becomes 1.
- SHIFT:
  - On each edge with `sen`=0, shift `sd` into a 21-bit shift register LSB-side and increment `bit_cnt`.
  - `bit_cnt` is 5 bits and saturates at 22; bits beyond 21 are dropped and the packet is marked overlong.
- SHIFT→IDLE, on the first edge with `sen`=1:
  - If `bit_cnt`==21: load `RB2_A`←sr[20:18] and `RB2_D`←sr[17:0], set `RB2_RW`←0, increment `pkt_cnt`.
  - Otherwise (short or overlong packet): discard, with no write and no count.
  - In both cases clear `bit_cnt`.
- Write strobe lasts exactly one cycle; `RB2_RW` returns to 1 on the next edge.
- `RB2_A`/`RB2_D` hold their values until the next valid packet.
- Repeated addresses overwrite; every valid packet counts toward `NUM_PKT`.
- When `pkt_cnt` reaches `NUM_PKT`:
  - Enter DONE on the edge that ends the strobe; `done`←1 on that same edge.
  - In DONE, `sen`/`sd` are ignored and `RB2_RW` stays 1.
- `rst` mid-packet or mid-strobe: all state is cleared immediately, and the partial packet is lost.

## Timing
- Reset values:
  - `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `done`=0.
  - FSM=IDLE, `bit_cnt`=0, `pkt_cnt`=0, shift register=0.
- Upstream drives `sen`/`sd` on falling edges; this block samples on rising edges (half-cycle setup).
- All outputs are registered; no combinational input-to-output path.
- Latency: the strobe (`RB2_RW`=0) is visible in the cycle following the first rising edge that samples `sen`=1 after bit 21. RB2 captures the write at the rising edge that ends the strobe.
- Back-to-back packets with a 1-cycle gap are supported:
  - The next packet's first bit can be sampled on the same edge that ends the strobe.
  - Shifting proceeds in parallel with the strobe; no data are lost.
- `done` rises one cycle after the 8th strobe asserts.

## Structure
- Package `rb2_link_pkg`:
  - `ADDR_W`, `DATA_W`, `NUM_PKT`, `PKT_BITS`=`ADDR_W+DATA_W`.
  - FSM state enum {IDLE, SHIFT, DONE}.
- Sub-module `serial_shift_rx`:
  - Contents: shift register plus saturating `bit_cnt`.
  - Outputs: `pkt_valid` (one-cycle pulse on `sen` rising with `bit_cnt`==`PKT_BITS`) and `pkt_data[20:0]`.
- Top level: FSM, `pkt_cnt`, RB2 output registers.

## Test plan
- Reset: `rst` pulse → `RB2_RW`=1, `RB2_A`=0, `RB2_D`=0, `done`=0; 10 idle cycles with `sen`=1 → no strobe.
- Single packet A=5, D=18'h2A5C3, then `sen`=1 → exactly one cycle `RB2_RW`=0 with `RB2_A`=5, `RB2_D`=18'h2A5C3; `pkt_cnt`=1.
- Eight packets A=0..7, D=18'h00001<<A, 1-cycle gaps → eight strobes in order with matching A/D; `done`=1 one cycle after the 8th strobe; further `sen` activity → no strobes, `done` stays 1.
- Malformed: 20-bit packet, then 22-bit packet → no strobe; a following valid packet A=3, D=18'h3FFFF → one strobe, `pkt_cnt`=1.
- Reset after 10 bits of a packet → all state cleared; a following full valid packet A=1, D=18'h12345 → strobe with A=1, D=18'h12345.
- Duplicate address: packets A=2, D=18'h11111, then A=2, D=18'h22222 → two strobes; RB2 model holds 18'h22222 at address 2; `pkt_cnt`=2.
